framebuffer_arbiter: RTL and testbench

//  Shares one single-port synchronous frame-buffer RAM between the VGA display

---
 rtl/fbarb_pkg.sv | 19 +
 rtl/fbarb_fifo.sv | 65 ++++++
 rtl/framebuffer_arbiter.sv | 149 ++++++++++++++
 tb/tb_framebuffer_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fbarb_pkg.sv
// Shared types and constants for the frame-buffer arbiter.
package fbarb_pkg;

    localparam int FBARB_ADDR_W = 16;
    localparam int FBARB_RGB_W  = 3;
    localparam int DISP_LATENCY = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } fbarb_state_t;

    typedef struct packed {
        logic [FBARB_ADDR_W-1:0] addr;
        logic [FBARB_RGB_W-1:0]  rgb;
    } fbarb_entry_t;

endpackage

// File: rtl/fbarb_fifo.sv
// Synchronous FIFO with registered level/full/empty; push is refused when full,
// pop is ignored when empty.
module fbarb_fifo
    import fbarb_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = fbarb_entry_t
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // DEPTH is a power of two, so the pointers wrap on natural overflow
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)
            level_d = level_q + LVL_W'(1);
        else if (do_pop && !do_push)
            level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/framebuffer_arbiter.sv
// Single-port frame-buffer arbiter: display reads win, buffered writes drain in idle cycles.
// Optional double buffering (bank swap on vsync) under FBARB_DOUBLE_BUFFER_EN.
//   state | meaning
//   IDLE  | no RAM access, address held
//   RD    | display read of the front bank
//   WR    | FIFO head written to the back bank
module framebuffer_arbiter
    import fbarb_pkg::*;
#(
    parameter int ADDR_W     = FBARB_ADDR_W,
    parameter int RGB_W      = FBARB_RGB_W,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          disp_req,
    input  logic [ADDR_W-1:0]             disp_address,
    input  logic                          disp_vsync,
    output logic [RGB_W-1:0]              disp_rgb,
    output logic                          disp_valid,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_address,
    input  logic [RGB_W-1:0]              wr_rgb,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          swap_req,
    output logic                          swap_ack,
    output logic                          bank,
    output logic [ADDR_W:0]               mem_address,
    output logic                          mem_we,
    output logic [RGB_W-1:0]              mem_wdata,
    input  logic [RGB_W-1:0]              mem_rdata
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [RGB_W-1:0]  rgb;
    } entry_t;

    fbarb_state_t            state_q, state_d;
    logic [ADDR_W:0]         mem_address_q, mem_address_d;
    logic [RGB_W-1:0]        mem_wdata_q, mem_wdata_d;
    logic [DISP_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
    logic [RGB_W-1:0]        disp_rgb_q, disp_rgb_d;
    logic                    front_bank, wr_bank;
    logic                    fifo_full, fifo_empty, fifo_pop;
    entry_t                  fifo_head, fifo_in;

    assign fifo_in = '{addr: wr_address, rgb: wr_rgb};
    assign fifo_pop = (state_d == WR);

    fbarb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (wr_valid),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        state_d       = IDLE;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        if (disp_req) begin
            state_d       = RD;
            mem_address_d = {front_bank, disp_address};
        end else if (!fifo_empty) begin
            state_d       = WR;
            mem_address_d = {wr_bank, fifo_head.addr};
            mem_wdata_d   = fifo_head.rgb;
        end
        // bit k set: a read decided k edges ago; RAM data is ready one stage before the top
        rd_pipe_d  = {rd_pipe_q[DISP_LATENCY-2:0], state_d == RD};
        disp_rgb_d = rd_pipe_q[DISP_LATENCY-2] ? mem_rdata : disp_rgb_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            rd_pipe_q     <= '0;
            disp_rgb_q    <= '0;
        end else begin
            state_q       <= state_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            rd_pipe_q     <= rd_pipe_d;
            disp_rgb_q    <= disp_rgb_d;
        end
    end

`ifdef FBARB_DOUBLE_BUFFER_EN
    logic bank_q, bank_d;
    logic pending_q, pending_d;
    logic swap_ack_q, swap_ack_d;
    logic vsync_q;
    logic swap_now;

    // Swap only with an empty FIFO so no queued pixel lands in the new front bank
    assign swap_now = vsync_q && !disp_vsync && pending_q && fifo_empty;

    always_comb begin
        bank_d     = bank_q ^ swap_now;
        swap_ack_d = swap_now;
        pending_d  = swap_now ? 1'b0 : (pending_q | swap_req);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bank_q     <= 1'b0;
            pending_q  <= 1'b0;
            swap_ack_q <= 1'b0;
            vsync_q    <= 1'b1;
        end else begin
            bank_q     <= bank_d;
            pending_q  <= pending_d;
            swap_ack_q <= swap_ack_d;
            vsync_q    <= disp_vsync;
        end
    end

    assign front_bank = bank_q;
    assign wr_bank    = ~bank_q;
    assign swap_ack   = swap_ack_q;
`else
    logic unused_swap_inputs;
    assign unused_swap_inputs = ^{swap_req, disp_vsync};
    assign front_bank = 1'b0;
    assign wr_bank    = 1'b0;
    assign swap_ack   = 1'b0;
`endif

    assign bank        = front_bank;
    assign wr_ready    = !fifo_full;
    assign mem_address = mem_address_q;
    assign mem_we      = (state_q == WR);
    assign mem_wdata   = mem_wdata_q;
    assign disp_rgb    = disp_rgb_q;
    assign disp_valid  = rd_pipe_q[DISP_LATENCY-1];

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Scoreboard bench for framebuffer_arbiter: queued expectations checked by a negedge monitor.
module tb_framebuffer_arbiter;

    localparam int AW = 16;
    localparam int RW = 3;
    localparam int D  = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_address = '0;
    logic          disp_vsync = 1'b1;
    logic [RW-1:0] disp_rgb;
    logic          disp_valid;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_address = '0;
    logic [RW-1:0] wr_rgb = '0;
    logic [4:0]    fifo_level;
    logic          swap_req = 1'b0;
    logic          swap_ack;
    logic          bank;
    logic [AW:0]   mem_address;
    logic          mem_we;
    logic [RW-1:0] mem_wdata;
    logic [RW-1:0] mem_rdata;

    framebuffer_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .disp_req     (disp_req),
        .disp_address (disp_address),
        .disp_vsync   (disp_vsync),
        .disp_rgb     (disp_rgb),
        .disp_valid   (disp_valid),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_address   (wr_address),
        .wr_rgb       (wr_rgb),
        .fifo_level   (fifo_level),
        .swap_req     (swap_req),
        .swap_ack     (swap_ack),
        .bank         (bank),
        .mem_address  (mem_address),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #20 clock = ~clock;

    typedef struct { int at; logic [2:0] rgb; } rd_t;
    typedef struct { int at; logic [16:0] addr; logic [2:0] rgb; } wr_t;

    rd_t  rq[$];
    wr_t  wq[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic req_hist = 1'b0;
    logic tb_bank = 1'b0;
    logic [2:0] ram [0:131071];

    // Reads only touch low addresses, writes only high ones, so read data is a pure function
    function automatic logic [2:0] pix(input logic [16:0] a);
        return a[2:0] ^ a[7:5] ^ {a[16], 2'b00};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clock) begin
        cyc      <= cyc + 1;
        req_hist <= disp_req;
        if (mem_we) ram[mem_address] <= mem_wdata;
        mem_rdata <= ram[mem_address];
    end

    always @(negedge clock) begin : monitor
        rd_t r;
        wr_t w;
        if (reset) begin
            if (disp_valid) begin
                if (rq.size() == 0) check("spurious_disp_valid", disp_valid, 0);
                else begin
                    r = rq.pop_front();
                    check("rd_data", disp_rgb, r.rgb);
                    check("rd_latency", cyc - r.at, 2);
                end
            end else if (rq.size() > 0 && cyc - rq[0].at >= 2) begin
                check("rd_missing", disp_valid, 1);
                void'(rq.pop_front());
            end
            if (req_hist) check("we_during_rd", mem_we, 0);
            else if (wq.size() > 0 && wq[0].at < cyc) check("wr_issued", mem_we, 1);
            if (mem_we) begin
                if (wq.size() == 0) check("spurious_write", mem_we, 0);
                else begin
                    w = wq.pop_front();
                    check("wr_addr", mem_address, w.addr);
                    check("wr_data", mem_wdata, w.rgb);
                end
            end
        end
    end

    task automatic drive(input logic req, input logic [15:0] ra, input logic wv,
                         input logic [15:0] wa, input logic [2:0] wd);
        logic msb;
`ifdef FBARB_DOUBLE_BUFFER_EN
        msb = ~tb_bank;
`else
        msb = 1'b0;
`endif
        check("fifo_level", fifo_level, wq.size());
        check("wr_ready", wr_ready, wq.size() < D);
        disp_req = req; disp_address = ra;
        wr_valid = wv; wr_address = wa; wr_rgb = wd;
        if (req) rq.push_back('{at: cyc + 1, rgb: pix({tb_bank, ra})});
        if (wv && wq.size() < D) wq.push_back('{at: cyc + 1, addr: {msb, wa}, rgb: wd});
        @(negedge clock); #1;
    endtask

    function automatic logic [15:0] rnd_rd();
        return 16'($urandom & 32'h7FFF);
    endfunction

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int we_seen;
        for (int a = 0; a < 131072; a++) ram[a] = pix(17'(a));
        repeat (3) @(negedge clock);
        #1;
        check("rst_wr_ready", wr_ready, 1);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_bank", bank, 0);
        check("rst_disp_valid", disp_valid, 0);
        check("rst_swap_ack", swap_ack, 0);
        check("rst_mem_address", mem_address, 0);
        reset = 1'b1;

        // single read of address 5
        drive(1, 16'd5, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("rd5_valid", disp_valid, 1);
        check("rd5_rgb", disp_rgb, 3'b101);
        drive(0, 0, 0, 0, 0);

        // fill the FIFO behind continuous reads, then drain
        for (int i = 0; i < 16; i++) drive(1, rnd_rd(), 1, 16'h8000 + 16'(i), 3'(i));
        check("full_level", fifo_level, 16);
        check("full_ready", wr_ready, 0);
        drive(1, rnd_rd(), 1, 16'h9000, 3'd7);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 0, 0);
            check("drain_consec", mem_we, 1);
        end
        drive(0, 0, 0, 0, 0);
        check("drained_level", fifo_level, 0);
        check("drained_ready", wr_ready, 1);

        // alternating display requests with writes pending
        for (int i = 0; i < 4; i++) drive(1, rnd_rd(), 1, 16'h8100 + 16'(i), 3'(i + 3));
        for (int i = 0; i < 12; i++) drive(i % 2 == 0, rnd_rd(), 0, 0, 0);

`ifdef FBARB_DOUBLE_BUFFER_EN
        drive(1, rnd_rd(), 1, 16'h8300, 3'd1);
        drive(1, rnd_rd(), 1, 16'h8301, 3'd2);
        swap_req = 1'b1;
        drive(1, rnd_rd(), 0, 0, 0);
        swap_req = 1'b0;
        disp_vsync = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, rnd_rd(), 0, 0, 0);
            check("noswap_bank", bank, 0);
            check("noswap_ack", swap_ack, 0);
        end
        disp_vsync = 1'b1;
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);
        disp_vsync = 1'b0;
        drive(0, 0, 0, 0, 0);
        check("swap_ack_pulse", swap_ack, 1);
        check("swap_bank", bank, 1);
        tb_bank = 1'b1;
        drive(0, 0, 0, 0, 0);
        check("swap_ack_end", swap_ack, 0);
        check("swap_bank_hold", bank, 1);
        disp_vsync = 1'b1;
        drive(0, 0, 1, 16'h8400, 3'd5);
        drive(1, 16'd9, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);
`else
        swap_req = 1'b1;
        disp_vsync = 1'b0;
        drive(0, 0, 0, 0, 0);
        swap_req = 1'b0;
        drive(0, 0, 0, 0, 0);
        check("single_bank", bank, 0);
        check("single_ack", swap_ack, 0);
        disp_vsync = 1'b1;
        drive(0, 0, 0, 0, 0);
`endif

        // randomized traffic
        for (int i = 0; i < 300; i++)
            drive(1'($urandom % 2), rnd_rd(), ($urandom % 5) < 2,
                  16'($urandom | 32'h8000), 3'($urandom));
        for (int i = 0; i < 40 && (wq.size() + rq.size()) > 0; i++) drive(0, 0, 0, 0, 0);
        check("all_retired", wq.size() + rq.size(), 0);

        // reset with writes queued and a read in flight
        for (int i = 0; i < 5; i++) drive(1, rnd_rd(), 1, 16'hA000 + 16'(i), 3'(i));
        disp_req = 1'b0; wr_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_level", fifo_level, 0);
        check("midrst_valid", disp_valid, 0);
        check("midrst_ready", wr_ready, 1);
        check("midrst_we", mem_we, 0);
        rq.delete();
        wq.delete();
        tb_bank = 1'b0;
        @(negedge clock); #1;
        reset = 1'b1;
        we_seen = 0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0);
            if (mem_we) we_seen++;
        end
        check("midrst_no_writes", we_seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
